c2d_chip_emulator: RTL and testbench
====================================

Name: c2d_chip_emulator

Overview:
- Synthesizable emulator of the current-to-digital converter's digital interface.
- Responds to CONV, DXMIT_BAR and DCLK exactly as the chip does: runs a conversion, asserts DVALID_BAR, then shifts a 64-bit frame out on DOUT.
- Used in FPGA loopback builds and benches in place of the physical chip, so that the clock generator, readout logic and FIFO/pipe path can be checked against known data.

Parameters:
- NCH, 4, number of channels per frame.
- NBITS, 16, bits per channel word. The frame is NCH*NBITS = 64 bits.
- CONV_LAT, 300, SYS_CLK cycles from a detected CONV toggle to DVALID_BAR assertion.

Ports:
- SYS_CLK  input  1  10 MHz interface clock; the only clock in the block.
- RST_BAR  input  1  asynchronous, active-low reset.
- CONV  input  1  conversion control; every toggle (either edge) starts one conversion.
- DXMIT_BAR  input  1  active-low transmit request from the host.
- DCLK  input  1  serial data clock from the host; its period is at least 4 SYS_CLK periods.
- DOUT  output  1  serial data, MSB first.
- DVALID_BAR  output  1  active-low; low means a frame is ready.
- pattern_mode  input  1  0 = ramp pattern, 1 = fixed pattern.
- fixed_word  input  NBITS  base word used in fixed mode.
- frame_cnt  output  16  number of completed frames; wraps from 0xFFFF to 0.
- overrun  output  1  sticky flag: a CONV toggle was dropped because the block was busy.

Behaviour:
- Reset values (RST_BAR low, asynchronous): DOUT=0, DVALID_BAR=1, frame_cnt=0, overrun=0, state=IDLE, all synchronizer flops=0. overrun clears only on reset.
- Input synchronization:
  - CONV, DXMIT_BAR and DCLK each pass through a 2-flop synchronizer, followed by one history flop for edge detection.
  - A detected event therefore acts 3 SYS_CLK cycles after the pin changes.
- State IDLE:
  - On a detected CONV toggle: load the latency counter with CONV_LAT-1 and go to CONVERT.
- State CONVERT:
  - Decrement the counter each cycle.
  - When the counter reaches 0: load the 64-bit shift register with the frame, drive DVALID_BAR=0, go to READY.
  - Frame layout: channel 0 in the MSBs.
  - Ramp mode: word k = frame_cnt[NBITS-1:0] + k, modulo 2^NBITS.
  - Fixed mode: word k = fixed_word XOR k.
  - pattern_mode and fixed_word are sampled only at the load cycle.
- State READY:
  - Wait for synchronized DXMIT_BAR=0.
  - On that cycle: DVALID_BAR returns to 1, DOUT = shift register MSB, bit counter = 0, go to SHIFT.
- State SHIFT:
  - Detected DCLK rising edge: bit counter +1. The host samples DOUT on this edge.
  - Detected DCLK falling edge: shift the register left one bit; DOUT takes the new MSB.
  - When the bit counter reaches NCH*NBITS: go to IDLE, DOUT=0, frame_cnt +1.
  - Synchronized DXMIT_BAR returning to 1 before the frame completes: abort. Go to IDLE, DOUT=0, frame_cnt unchanged.
- Busy handling:
  - A CONV toggle detected in CONVERT, READY or SHIFT is dropped and sets overrun=1.
  - A CONV toggle on the same cycle that SHIFT completes is also dropped; it is not queued.
- Stuck READY: the block stays in READY indefinitely. A further CONV toggle is dropped and sets overrun.
- Reset mid-operation: immediate return to reset values; no partial frame is retained.

Test Plan:
- Reset release, CONV toggles 0->1 at t0, ramp mode -> DVALID_BAR falls exactly 3+300 cycles after t0. DXMIT_BAR low, then 64 DCLK pulses -> DOUT bits decode to words 0x0000, 0x0001, 0x0002, 0x0003; DVALID_BAR high after DXMIT_BAR is seen low; frame_cnt=1.
- Fixed mode, fixed_word=0xA5A0 -> frame reads 0xA5A0, 0xA5A1, 0xA5A2, 0xA5A3 MSB first; next CONV toggle (1->0) produces a second identical frame; frame_cnt=2.
- CONV toggled again 100 cycles into CONVERT -> overrun=1, only one frame produced. overrun stays 1 through later frames until RST_BAR pulse -> overrun=0, frame_cnt=0.
- DXMIT_BAR raised after 20 DCLK pulses -> DOUT=0, state IDLE, frame_cnt unchanged. Next conversion is accepted normally and starts from a freshly loaded frame.
- Force frame_cnt to 0xFFFF, complete one frame in ramp mode -> words 0xFFFF, 0x0000, 0x0001, 0x0002; frame_cnt wraps to 0x0000.
- RST_BAR asserted mid-SHIFT after 30 bits -> DOUT=0 and DVALID_BAR=1 immediately (asynchronous); no DOUT activity on subsequent DCLK pulses until a new CONV toggle.

Source files
------------

// File: rtl/c2d_chip_emulator.sv
// c2d_chip_emulator: behavioural stand-in for the current-to-digital
// converter's digital interface. A CONV toggle starts a conversion. After
// CONV_LAT cycles a 64-bit frame is latched and DVALID_BAR falls. The host
// then pulls DXMIT_BAR low and clocks the frame out on DOUT with DCLK.
//
// Handshake: DVALID_BAR low means a frame is held and ready for readout.
// The host requests the frame by driving DXMIT_BAR low. The first cycle
// that sees the synchronized request low clears DVALID_BAR and presents
// the frame MSB on DOUT. The request must then stay low until the last bit
// has been clocked out. Raising it earlier abandons the frame.
module c2d_chip_emulator #(
  parameter int NCH      = 4,
  parameter int NBITS    = 16,
  parameter int CONV_LAT = 300
) (
  input  logic             SYS_CLK,
  input  logic             RST_BAR,
  input  logic             CONV,
  input  logic             DXMIT_BAR,
  input  logic             DCLK,
  output logic             DOUT,
  output logic             DVALID_BAR,
  input  logic             pattern_mode,
  input  logic [NBITS-1:0] fixed_word,
  output logic [15:0]      frame_cnt,
  output logic             overrun,
  output logic [1:0]       state_dbg
);

  localparam int FRAME_W = NCH * NBITS;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam int LAT_W   = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READY   = 2'd2,
    ST_SHIFT   = 2'd3
  } state_t;

  // Synchronizer bit order: {DCLK, DXMIT_BAR, CONV}.
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  // History flops for edge detection: {DCLK, CONV}. DXMIT_BAR is level-sensitive.
  logic [1:0]         hist_q, hist_d;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               dout_q, dout_d;
  logic               dvalid_bar_q, dvalid_bar_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;

  logic               conv_evt;
  logic               dxmit_s;
  logic               dclk_rise;
  logic               dclk_fall;

  // Build a frame with channel 0 in the MSBs.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic             mode,
    input logic [NBITS-1:0] fw,
    input logic [NBITS-1:0] base
  );
    logic [FRAME_W-1:0] f;
    logic [NBITS-1:0]   kw;
    logic [NBITS-1:0]   word;
    f = '0;
    for (int k = 0; k < NCH; k++) begin
      kw   = NBITS'(k);
      word = mode ? (fw ^ kw) : (base + kw);
      f[FRAME_W-1-k*NBITS -: NBITS] = word;
    end
    return f;
  endfunction

  // Synchronizer and history next values, plus decoded pin events.
  always_comb begin
    sync1_d   = {DCLK, DXMIT_BAR, CONV};
    sync2_d   = sync1_q;
    hist_d    = {sync2_q[2], sync2_q[0]};
    conv_evt  = sync2_q[0] ^ hist_q[0];
    dxmit_s   = sync2_q[1];
    dclk_rise = sync2_q[2] & ~hist_q[1];
    dclk_fall = ~sync2_q[2] & hist_q[1];
  end

  // Input synchronizers and edge-detect history.
  always_ff @(posedge SYS_CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // Conversion/readout FSM: next state, datapath and output next values.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    sr_d         = sr_q;
    bcnt_d       = bcnt_q;
    dout_d       = dout_q;
    dvalid_bar_d = dvalid_bar_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;

    // Toggles arriving while busy are dropped rather than queued.
    if (conv_evt && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        if (conv_evt) begin
          lat_d   = LAT_W'(CONV_LAT - 1);
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (lat_q == '0) begin
          sr_d         = build_frame(pattern_mode, fixed_word, NBITS'(frame_cnt_q));
          dvalid_bar_d = 1'b0;
          state_d      = ST_READY;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_READY: begin
        if (!dxmit_s) begin
          dvalid_bar_d = 1'b1;
          dout_d       = sr_q[FRAME_W-1];
          bcnt_d       = '0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (dxmit_s) begin
          // Host withdrew the request: abandon the frame.
          dout_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (dclk_rise) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(FRAME_W - 1)) begin
            dout_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end
        end else if (dclk_fall) begin
          sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
          dout_d = sr_q[FRAME_W-2];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge SYS_CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      sr_q         <= '0;
      bcnt_q       <= '0;
      dout_q       <= 1'b0;
      dvalid_bar_q <= 1'b1;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      sr_q         <= sr_d;
      bcnt_q       <= bcnt_d;
      dout_q       <= dout_d;
      dvalid_bar_q <= dvalid_bar_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  // Output mapping.
  always_comb begin
    DOUT       = dout_q;
    DVALID_BAR = dvalid_bar_q;
    frame_cnt  = frame_cnt_q;
    overrun    = overrun_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_c2d_chip_emulator.sv
// Bench for c2d_chip_emulator: a host-side driver and a frame reference model.
module tb_c2d_chip_emulator;

  localparam int CONV_LAT = 300;
  localparam int EXP_LAT  = CONV_LAT + 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READY = 2'd2;

  logic        SYS_CLK = 1'b0;
  logic        RST_BAR = 1'b0;
  logic        CONV = 1'b0;
  logic        DXMIT_BAR = 1'b1;
  logic        DCLK = 1'b0;
  logic        DOUT;
  logic        DVALID_BAR;
  logic        pattern_mode = 1'b0;
  logic [15:0] fixed_word = 16'h0000;
  logic [15:0] frame_cnt;
  logic        overrun;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_fcnt = 0;

  c2d_chip_emulator #(.NCH(4), .NBITS(16), .CONV_LAT(CONV_LAT)) dut (
    .SYS_CLK(SYS_CLK), .RST_BAR(RST_BAR), .CONV(CONV), .DXMIT_BAR(DXMIT_BAR),
    .DCLK(DCLK), .DOUT(DOUT), .DVALID_BAR(DVALID_BAR), .pattern_mode(pattern_mode),
    .fixed_word(fixed_word), .frame_cnt(frame_cnt), .overrun(overrun), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 SYS_CLK = ~SYS_CLK;
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // Reference frame: four 16-bit words, word 0 first on the wire.
  function automatic logic [63:0] model_frame(input logic mode, input logic [15:0] fw, input int fcnt);
    logic [63:0] f;
    int w;
    f = 64'd0;
    for (int k = 0; k < 4; k++) begin
      w = mode ? (int'(fw) ^ k) : ((fcnt + k) % 65536);
      f = {f[47:0], w[15:0]};
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic hold_reset();
    @(negedge SYS_CLK);
    RST_BAR = 1'b0; CONV = 1'b0; DXMIT_BAR = 1'b1; DCLK = 1'b0;
    repeat (3) @(negedge SYS_CLK);
  endtask

  task automatic release_reset();
    RST_BAR = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    exp_fcnt = 0;
  endtask

  task automatic toggle_conv(output int t0);
    @(negedge SYS_CLK);
    CONV = ~CONV;
    t0 = cyc;
  endtask

  task automatic wait_dvalid(input int t0, input int limit, output int lat);
    int n;
    lat = -1;
    n = 0;
    while (lat < 0 && n < limit) begin
      @(negedge SYS_CLK);
      n++;
      if (DVALID_BAR === 1'b0) lat = cyc - t0;
    end
  endtask

  task automatic read_frame(input int nbits, input int half, output logic [63:0] bits, output logic dv_during);
    bits = 64'd0;
    @(negedge SYS_CLK);
    DXMIT_BAR = 1'b0;
    repeat (5) @(negedge SYS_CLK);
    dv_during = DVALID_BAR;
    for (int i = 0; i < nbits; i++) begin
      bits[63-i] = DOUT;
      DCLK = 1'b1;
      repeat (half) @(negedge SYS_CLK);
      DCLK = 1'b0;
      repeat (half) @(negedge SYS_CLK);
    end
  endtask

  task automatic finish_xmit();
    @(negedge SYS_CLK);
    DXMIT_BAR = 1'b1;
    repeat (4) @(negedge SYS_CLK);
  endtask

  task automatic run_frame(input logic mode, input logic [15:0] fw, input int half,
                           output int lat, output logic [63:0] bits, output logic dv);
    int t0;
    pattern_mode = mode;
    fixed_word = fw;
    toggle_conv(t0);
    wait_dvalid(t0, 1000, lat);
    read_frame(64, half, bits, dv);
    finish_xmit();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge SYS_CLK);
    checks++; if (DOUT !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", DOUT); end
    checks++; if (DVALID_BAR !== 1'b1) begin failures++; $display("FAIL reset_dvalid got=%b exp=1", DVALID_BAR); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0h exp=0", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    release_reset();
  endtask

  task automatic test_ramp_first();
    int t0, lat;
    logic [63:0] bits, exp;
    logic dv;
    pattern_mode = 1'b0;
    toggle_conv(t0);
    wait_dvalid(t0, 1000, lat);
    checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL ramp_latency got=%0d exp=%0d", lat, EXP_LAT); end
    checks++; if (state_dbg !== S_READY) begin failures++; $display("FAIL ramp_ready_state got=%0d exp=%0d", state_dbg, S_READY); end
    read_frame(64, 4, bits, dv);
    finish_xmit();
    exp = model_frame(1'b0, 16'h0, exp_fcnt);
    checks++; if (dv !== 1'b1) begin failures++; $display("FAIL ramp_dvalid_cleared got=%b exp=1", dv); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bits[63-16*k -: 16] !== exp[63-16*k -: 16]) begin
        failures++; $display("FAIL ramp_word%0d got=%0h exp=%0h", k, bits[63-16*k -: 16], exp[63-16*k -: 16]);
      end
    end
    exp_fcnt = (exp_fcnt + 1) % 65536;
    checks++; if (frame_cnt !== 16'(exp_fcnt)) begin failures++; $display("FAIL ramp_frame_cnt got=%0h exp=%0h", frame_cnt, exp_fcnt); end
    checks++; if (DOUT !== 1'b0) begin failures++; $display("FAIL ramp_dout_idle got=%b exp=0", DOUT); end
  endtask

  task automatic test_fixed();
    int lat;
    logic [63:0] bits, exp;
    logic dv;
    exp = model_frame(1'b1, 16'hA5A0, exp_fcnt);
    for (int n = 0; n < 2; n++) begin
      run_frame(1'b1, 16'hA5A0, 4, lat, bits, dv);
      exp_fcnt = (exp_fcnt + 1) % 65536;
      checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL fixed_latency%0d got=%0d exp=%0d", n, lat, EXP_LAT); end
      checks++; if (bits !== exp) begin failures++; $display("FAIL fixed_frame%0d got=%0h exp=%0h", n, bits, exp); end
    end
    checks++; if (frame_cnt !== 16'(exp_fcnt)) begin failures++; $display("FAIL fixed_frame_cnt got=%0h exp=%0h", frame_cnt, exp_fcnt); end
  endtask

  task automatic test_overrun();
    int t0, t1, lat;
    logic [63:0] bits, exp;
    logic dv;
    pattern_mode = 1'b0;
    toggle_conv(t0);
    repeat (100) @(negedge SYS_CLK);
    toggle_conv(t1);
    repeat (5) @(negedge SYS_CLK);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    wait_dvalid(t0, 1000, lat);
    checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL overrun_latency got=%0d exp=%0d", lat, EXP_LAT); end
    read_frame(64, 5, bits, dv);
    finish_xmit();
    exp = model_frame(1'b0, 16'h0, exp_fcnt);
    exp_fcnt = (exp_fcnt + 1) % 65536;
    checks++; if (bits !== exp) begin failures++; $display("FAIL overrun_frame got=%0h exp=%0h", bits, exp); end
    repeat (400) @(negedge SYS_CLK);
    checks++; if (DVALID_BAR !== 1'b1 || state_dbg !== S_IDLE) begin
      failures++; $display("FAIL overrun_single_frame got dvalid=%b state=%0d exp dvalid=1 state=0", DVALID_BAR, state_dbg);
    end
    exp = model_frame(1'b0, 16'h0, exp_fcnt);
    run_frame(1'b0, 16'h0, 4, lat, bits, dv);
    exp_fcnt = (exp_fcnt + 1) % 65536;
    checks++; if (bits !== exp) begin failures++; $display("FAIL overrun_next_frame got=%0h exp=%0h", bits, exp); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    hold_reset();
    release_reset();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_cleared got=%b exp=0", overrun); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL overrun_reset_cnt got=%0h exp=0", frame_cnt); end
  endtask

  task automatic test_abort();
    int t0, lat;
    logic [63:0] bits, exp;
    logic dv;
    pattern_mode = 1'b0;
    exp = model_frame(1'b0, 16'h0, exp_fcnt);
    toggle_conv(t0);
    wait_dvalid(t0, 1000, lat);
    read_frame(20, 4, bits, dv);
    finish_xmit();
    checks++; if (bits[63:44] !== exp[63:44]) begin failures++; $display("FAIL abort_partial got=%0h exp=%0h", bits[63:44], exp[63:44]); end
    checks++; if (DOUT !== 1'b0) begin failures++; $display("FAIL abort_dout got=%b exp=0", DOUT); end
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=0", state_dbg); end
    checks++; if (frame_cnt !== 16'(exp_fcnt)) begin failures++; $display("FAIL abort_frame_cnt got=%0h exp=%0h", frame_cnt, exp_fcnt); end
    run_frame(1'b0, 16'h0, 4, lat, bits, dv);
    exp_fcnt = (exp_fcnt + 1) % 65536;
    checks++; if (bits !== exp) begin failures++; $display("FAIL abort_fresh_frame got=%0h exp=%0h", bits, exp); end
  endtask

  task automatic test_random();
    int lat, half;
    logic mode;
    logic [15:0] fw;
    logic [63:0] bits, exp;
    logic dv;
    for (int n = 0; n < 6; n++) begin
      mode = 1'($urandom_range(0, 1));
      fw = 16'($urandom);
      half = $urandom_range(4, 6);
      repeat ($urandom_range(1, 20)) @(negedge SYS_CLK);
      exp = model_frame(mode, fw, exp_fcnt);
      run_frame(mode, fw, half, lat, bits, dv);
      exp_fcnt = (exp_fcnt + 1) % 65536;
      checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, EXP_LAT); end
      checks++; if (bits !== exp) begin failures++; $display("FAIL rand%0d_frame got=%0h exp=%0h", n, bits, exp); end
      checks++; if (frame_cnt !== 16'(exp_fcnt)) begin failures++; $display("FAIL rand%0d_frame_cnt got=%0h exp=%0h", n, frame_cnt, exp_fcnt); end
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [63:0] bits, exp;
    logic dv;
    @(negedge SYS_CLK);
    force dut.frame_cnt_d = 16'hFFFF;
    @(negedge SYS_CLK);
    release dut.frame_cnt_d;
    exp_fcnt = 65535;
    checks++; if (frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0h exp=ffff", frame_cnt); end
    exp = model_frame(1'b0, 16'h0, exp_fcnt);
    run_frame(1'b0, 16'h0, 4, lat, bits, dv);
    exp_fcnt = (exp_fcnt + 1) % 65536;
    checks++; if (bits !== exp) begin failures++; $display("FAIL wrap_frame got=%0h exp=%0h", bits, exp); end
    checks++; if (frame_cnt !== 16'(exp_fcnt)) begin failures++; $display("FAIL wrap_frame_cnt got=%0h exp=%0h", frame_cnt, exp_fcnt); end
  endtask

  task automatic test_stuck_ready();
    int t0, t1, lat;
    pattern_mode = 1'b0;
    toggle_conv(t0);
    wait_dvalid(t0, 1000, lat);
    checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL stuck_latency got=%0d exp=%0d", lat, EXP_LAT); end
    repeat (500) @(negedge SYS_CLK);
    checks++; if (DVALID_BAR !== 1'b0 || state_dbg !== S_READY) begin
      failures++; $display("FAIL stuck_hold got dvalid=%b state=%0d exp dvalid=0 state=2", DVALID_BAR, state_dbg);
    end
    toggle_conv(t1);
    repeat (5) @(negedge SYS_CLK);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL stuck_overrun got=%b exp=1", overrun); end
    checks++; if (DVALID_BAR !== 1'b0) begin failures++; $display("FAIL stuck_still_ready got=%b exp=0", DVALID_BAR); end
    #2;
    RST_BAR = 1'b0;
    #1;
    checks++; if (DVALID_BAR !== 1'b1) begin failures++; $display("FAIL stuck_async_dvalid got=%b exp=1", DVALID_BAR); end
    checks++; if (overrun !== 1'b0 || state_dbg !== S_IDLE) begin
      failures++; $display("FAIL stuck_async_reset got overrun=%b state=%0d exp overrun=0 state=0", overrun, state_dbg);
    end
    hold_reset();
    release_reset();
  endtask

  task automatic test_reset_mid_shift();
    int t0, lat, ones;
    logic [63:0] bits, exp;
    logic dv;
    pattern_mode = 1'b1;
    fixed_word = 16'hFFFF;
    exp = model_frame(1'b1, 16'hFFFF, exp_fcnt);
    toggle_conv(t0);
    wait_dvalid(t0, 1000, lat);
    read_frame(30, 4, bits, dv);
    checks++; if (bits[63:34] !== exp[63:34]) begin failures++; $display("FAIL mid_partial got=%0h exp=%0h", bits[63:34], exp[63:34]); end
    checks++; if (DOUT !== exp[33]) begin failures++; $display("FAIL mid_bit30 got=%b exp=%b", DOUT, exp[33]); end
    #2;
    RST_BAR = 1'b0;
    #1;
    checks++; if (DOUT !== 1'b0) begin failures++; $display("FAIL mid_async_dout got=%b exp=0", DOUT); end
    checks++; if (DVALID_BAR !== 1'b1 || frame_cnt !== 16'd0) begin
      failures++; $display("FAIL mid_async_state got dvalid=%b cnt=%0h exp dvalid=1 cnt=0", DVALID_BAR, frame_cnt);
    end
    CONV = 1'b0;
    DCLK = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    release_reset();
    DXMIT_BAR = 1'b0;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      DCLK = 1'b1;
      repeat (4) begin @(negedge SYS_CLK); if (DOUT !== 1'b0) ones++; end
      DCLK = 1'b0;
      repeat (4) begin @(negedge SYS_CLK); if (DOUT !== 1'b0) ones++; end
    end
    checks++; if (ones != 0) begin failures++; $display("FAIL mid_dout_quiet got=%0d exp=0", ones); end
    checks++; if (state_dbg !== S_IDLE || DVALID_BAR !== 1'b1) begin
      failures++; $display("FAIL mid_idle got state=%0d dvalid=%b exp state=0 dvalid=1", state_dbg, DVALID_BAR);
    end
    finish_xmit();
  endtask

  // Watchdog: ends the run if any wait above stalls.
  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report.
  initial begin
    test_reset();
    test_ramp_first();
    test_fixed();
    test_overrun();
    test_abort();
    test_random();
    test_wrap();
    test_stuck_ready();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
